mpc_constraint_bound_table: RTL and testbench
=============================================

# mpc_constraint_bound_table

Double-buffered, run-time-writable table of signed fixed-point constraint bounds for the dense-constraint stage of the implicit MPC controller. It replaces the fixed per-row bound ROM. The table adds three things:
- a host-side write port into a shadow bank;
- a glitch-free bank swap, deferred to a sweep boundary;
- a streaming sweep port with valid/ready backpressure for the constraint-row pipeline.

A single-cycle random-access read port is kept for the existing pipeline loops.

## Interface
- DATA_W, 20, bound word width (signed two's complement fixed point)
- ROWS, 8, constraint rows per bank (≥2)
- ADDR_W, $clog2(ROWS), row address width
- INIT_EVEN, 20'hA0000, initial content of even rows, both banks
- INIT_ODD, 20'h6487F, initial content of odd rows, both banks
- BOUND_MIN / BOUND_MAX, 20'h80000 / 20'h7FFFF, clamp limits (signed)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address0  in  ADDR_W  random-read row address, active bank
- ce0  in  1  random-read enable
- q0  out  DATA_W  random-read data
- wr_en  in  1  shadow-bank write strobe
- wr_addr  in  ADDR_W  shadow-bank write row
- wr_data  in  DATA_W  shadow-bank write data
- commit  in  1  request active/shadow swap (pulse)
- commit_pending  out  1  swap requested, not yet performed
- commit_done  out  1  one-cycle pulse on the cycle the swap occurs
- bank_sel  out  1  index of the active bank
- start  in  1  begin a sweep of rows 0..ROWS-1 (pulse)
- busy  out  1  sweep in progress
- s_valid  out  1  stream data valid
- s_ready  in  1  downstream ready
- s_data  out  DATA_W  stream row value
- s_last  out  1  marks row ROWS-1

## Operation
- Storage: two banks of ROWS×DATA_W words, initialised at configuration (row r = INIT_EVEN if r even, else INIT_ODD). Contents are not altered by reset.
- Random port: when ce0=1, q0 <= active[address0] at the next edge. q0 holds when ce0=0.
- Write: when wr_en=1 and wr_addr<ROWS, shadow[wr_addr] <= wr_data. Writes with wr_addr≥ROWS are ignored. Writes never touch the active bank.
- Commit:
  - commit=1 sets commit_pending.
  - The swap happens on the first edge with commit_pending=1, state IDLE, and start=0.
  - On the swap: bank_sel toggles, commit_pending clears, commit_done=1 for one cycle.
  - A write and a commit in the same cycle: the write lands in the pre-swap shadow bank, so it is included in the swap.
  - commit while already pending has no extra effect.
- Sweep FSM:
  - IDLE: on start=1, latch the current bank_sel as sweep bank, rd_ptr<=0, go to RUN.
  - RUN: advance = !s_valid || s_ready. On advance with rows left to issue, s_data <= bank[rd_ptr], s_valid<=1, s_last <= (rd_ptr==ROWS-1), rd_ptr++. On advance with nothing left to issue, s_valid<=0.
  - When the s_last beat handshakes (s_valid & s_ready & s_last): go to IDLE.
- start is ignored outside IDLE.
- s_data, s_last and s_valid are stable while s_valid=1 and s_ready=0.
- A swap is never performed in RUN. A sweep always reads one bank consistently.

## Timing
- Reset values: q0=0, s_data=0, s_valid=0, s_last=0, busy=0, commit_pending=0, commit_done=0, bank_sel=0, FSM=IDLE, rd_ptr=0.
- Reset mid-sweep: aborts immediately; all of the above apply. A pending commit is dropped.
- Random read latency: 1 cycle.
- Sweep timing:
  - start sampled at edge k; busy=1 from k.
  - First beat valid after edge k+1.
  - With s_ready held 1, one row per cycle; last beat after edge k+ROWS.
  - busy=0 and IDLE after the edge that consumes the last beat.
  - A new start is accepted from the following cycle.
- Swap latency: when idle, commit at edge k gives bank_sel toggle and commit_done at edge k+1. During a sweep, the swap happens one edge after return to IDLE (if start=0).

## Configuration
- MPC_BOUND_CLAMP_EN defined: wr_data is saturated to [BOUND_MIN, BOUND_MAX] (signed compare) before storage.
- Not defined: wr_data is stored verbatim and BOUND_MIN/BOUND_MAX are unused.

## Test plan
- Reset, then random reads of rows 0..7 with ce0=1 -> q0 = A0000, 6487F, alternating, each one cycle after its address.
- start with s_ready=1 -> 8 consecutive beats, s_last only on beat 8, busy drops the cycle after beat 8.
- Sweep with s_ready toggling 1/0 -> s_data held while stalled, no row lost or duplicated, row order 0..7.
- Write shadow[3]=12345, commit mid-sweep -> the sweep returns 6487F for row 3, the swap follows sweep end, and the next sweep returns 12345.
- Write and commit in the same cycle while idle -> commit_done next cycle, and q0 for row 3 reads the new value.
- With MPC_BOUND_CLAMP_EN and BOUND_MAX=40000, write 7FFFF -> stored 40000. Without the macro -> stored 7FFFF. Reset asserted mid-sweep -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mpc_constraint_bound_table.sv
// Double-buffered constraint bound table: host writes the shadow bank, commit swaps banks between sweeps,
// a valid/ready stream sweeps the active bank. Define MPC_BOUND_CLAMP_EN to saturate write data to BOUND_MIN/BOUND_MAX.
module mpc_constraint_bound_table #(
  parameter int                        DATA_W    = 20,
  parameter int                        ROWS      = 8,
  parameter int                        ADDR_W    = $clog2(ROWS),
  parameter logic        [DATA_W-1:0]  INIT_EVEN = 20'hA0000,
  parameter logic        [DATA_W-1:0]  INIT_ODD  = 20'h6487F,
  parameter logic signed [DATA_W-1:0]  BOUND_MIN = 20'h80000,
  parameter logic signed [DATA_W-1:0]  BOUND_MAX = 20'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address0,
  input  logic              ce0,
  output logic [DATA_W-1:0] q0,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic              commit_done,
  output logic              bank_sel,
  input  logic              start,
  output logic              busy,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last
);

`ifdef MPC_BOUND_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam int              PTR_W    = ADDR_W + 1;
  localparam logic [PTR_W-1:0] ROWS_P  = PTR_W'(ROWS);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(ROWS - 1);

  typedef logic [1:0][ROWS-1:0][DATA_W-1:0] mem_t;
  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        m[b][r] = (r % 2 == 0) ? INIT_EVEN : INIT_ODD;
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] sat_bound(input logic signed [DATA_W-1:0] v);
    if (v > BOUND_MAX) return BOUND_MAX;
    if (v < BOUND_MIN) return BOUND_MIN;
    return v;
  endfunction

  // Bank contents are configuration-initialised and deliberately outside the reset domain.
  mem_t mem_q = init_mem();
  mem_t mem_d;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              sweep_bank_q, sweep_bank_d;
  logic [DATA_W-1:0] q0_q, q0_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              s_valid_q, s_valid_d;
  logic              s_last_q, s_last_d;
  logic              commit_pending_q, commit_pending_d;
  logic              commit_done_q, commit_done_d;
  logic              bank_sel_q, bank_sel_d;
  logic              swap;
  logic              advance;
  logic [DATA_W-1:0] wr_val;

  always_comb begin
    wr_val           = CLAMP_EN ? sat_bound(wr_data) : wr_data;
    swap             = commit_pending_q && (state_q == S_IDLE) && !start;
    advance          = !s_valid_q || s_ready;

    mem_d            = mem_q;
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    sweep_bank_d     = sweep_bank_q;
    s_data_d         = s_data_q;
    s_valid_d        = s_valid_q;
    s_last_d         = s_last_q;
    commit_pending_d = swap ? 1'b0 : (commit_pending_q | commit);
    commit_done_d    = swap;
    bank_sel_d       = bank_sel_q ^ swap;
    q0_d             = ce0 ? mem_q[bank_sel_q][address0] : q0_q;

    // Writes target the pre-swap shadow bank, so a same-cycle commit includes them.
    if (wr_en && ({1'b0, wr_addr} < ROWS_P))
      mem_d[~bank_sel_q][wr_addr] = wr_val;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sweep_bank_d = bank_sel_q;
          rd_ptr_d     = '0;
          state_d      = S_RUN;
        end
      end
      default: begin
        if (advance) begin
          if (rd_ptr_q < ROWS_P) begin
            s_data_d  = mem_q[sweep_bank_q][rd_ptr_q[ADDR_W-1:0]];
            s_valid_d = 1'b1;
            s_last_d  = (rd_ptr_q == LAST_P);
            rd_ptr_d  = rd_ptr_q + 1'b1;
          end else begin
            s_valid_d = 1'b0;
            s_last_d  = 1'b0;
          end
        end
        if (s_valid_q && s_ready && s_last_q)
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      rd_ptr_q         <= '0;
      sweep_bank_q     <= 1'b0;
      q0_q             <= '0;
      s_data_q         <= '0;
      s_valid_q        <= 1'b0;
      s_last_q         <= 1'b0;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      bank_sel_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      sweep_bank_q     <= sweep_bank_d;
      q0_q             <= q0_d;
      s_data_q         <= s_data_d;
      s_valid_q        <= s_valid_d;
      s_last_q         <= s_last_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      bank_sel_q       <= bank_sel_d;
    end
  end

  assign q0             = q0_q;
  assign s_data         = s_data_q;
  assign s_valid        = s_valid_q;
  assign s_last         = s_last_q;
  assign busy           = (state_q == S_RUN);
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign bank_sel       = bank_sel_q;

endmodule

// File: tb/tb_mpc_constraint_bound_table.sv
// Scoreboard bench for mpc_constraint_bound_table: random reads, sweeps with backpressure,
// deferred commit, same-cycle write+commit, optional clamp and asynchronous reset mid-sweep.
module tb_mpc_constraint_bound_table;
  localparam int DW = 20;
  localparam int ROWS = 8;
  localparam int AW = 3;
  localparam logic [DW-1:0] EVEN = 20'hA0000;
  localparam logic [DW-1:0] ODD  = 20'h6487F;
  localparam logic [DW-1:0] BMIN = 20'hC0000;
  localparam logic [DW-1:0] BMAX = 20'h40000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address0 = '0;
  logic          ce0 = 1'b0;
  logic [DW-1:0] q0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          commit_pending, commit_done, bank_sel;
  logic          start = 1'b0;
  logic          busy, s_valid, s_last;
  logic          s_ready = 1'b1;
  logic [DW-1:0] s_data;

  mpc_constraint_bound_table #(
    .DATA_W(DW), .ROWS(ROWS), .ADDR_W(AW),
    .INIT_EVEN(EVEN), .INIT_ODD(ODD),
    .BOUND_MIN(BMIN), .BOUND_MAX(BMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .address0(address0), .ce0(ce0), .q0(q0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .commit_done(commit_done), .bank_sel(bank_sel),
    .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW:0]   sb[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] mdl [2][ROWS];
  logic          msel;
  bit            toggle = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_store(input logic [DW-1:0] v);
`ifdef MPC_BOUND_CLAMP_EN
    if ($signed(v) > $signed(BMAX)) return BMAX;
    if ($signed(v) < $signed(BMIN)) return BMIN;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    s_ready = toggle ? ~s_ready : 1'b1;
  endtask

  // Stream monitor: every handshake pops the next expected {last, data}.
  always @(negedge clk) begin
    if (!reset && s_valid && s_ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        logic [DW:0] e;
        e = sb.pop_front();
        chk("s_data", s_data, e[DW-1:0]);
        chk("s_last", s_last, e[DW]);
      end
    end
  end

  task automatic rd(input int r);
    ce0 = 1'b1;
    address0 = AW'(r);
    rq.push_back(mdl[msel][r]);
    tick();
    ce0 = 1'b0;
    chk("q0_read", q0, rq.pop_front());
  endtask

  task automatic wr(input int r, input logic [DW-1:0] d, input bit with_commit);
    wr_en = 1'b1;
    wr_addr = AW'(r);
    wr_data = d;
    commit = with_commit;
    tick();
    wr_en = 1'b0;
    commit = 1'b0;
    mdl[~msel][r] = exp_store(d);
  endtask

  task automatic start_sweep();
    start = 1'b1;
    for (int r = 0; r < ROWS; r++) sb.push_back({(r == ROWS - 1), mdl[msel][r]});
    tick();
    start = 1'b0;
    chk("busy_start", busy, 1);
  endtask

  task automatic sweep_fixed(input int commit_at);
    for (int i = 1; i <= ROWS; i++) begin
      if (i == commit_at) commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("s_valid_beat", s_valid, 1);
      chk("s_last_beat", s_last, (i == ROWS));
    end
    tick();
    chk("busy_end", busy, 0);
    chk("s_valid_end", s_valid, 0);
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("sweep_done_busy", busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    msel = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) mdl[b][r] = (r % 2 == 0) ? EVEN : ODD;

    tick();
    tick();
    chk("rst_q0", q0, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_last", s_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", commit_pending, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_bank_sel", bank_sel, 0);
    reset = 1'b0;
    tick();

    for (int r = 0; r < ROWS; r++) rd(r);
    address0 = 3'd2;
    tick();
    chk("q0_hold", q0, ODD);

    start_sweep();
    sweep_fixed(0);

    toggle = 1'b1;
    start_sweep();
    wait_done(100);
    toggle = 1'b0;
    tick();

    // Commit during a sweep is deferred until one edge after the sweep ends.
    wr(3, 20'h12345, 1'b0);
    start_sweep();
    sweep_fixed(3);
    chk("defer_pending", commit_pending, 1);
    chk("defer_bank_sel", bank_sel, msel);
    chk("defer_done", commit_done, 0);
    tick();
    chk("swap_done", commit_done, 1);
    chk("swap_pending", commit_pending, 0);
    msel = ~msel;
    chk("swap_bank_sel", bank_sel, msel);
    tick();
    chk("done_pulse", commit_done, 0);
    start_sweep();
    sweep_fixed(0);

    wr(3, 20'h54321, 1'b1);
    chk("wc_pending", commit_pending, 1);
    chk("wc_done_early", commit_done, 0);
    tick();
    chk("wc_done", commit_done, 1);
    msel = ~msel;
    chk("wc_bank_sel", bank_sel, msel);
    rd(3);
    rd(4);

    wr(0, 20'h7FFFF, 1'b0);
    wr(1, 20'h80000, 1'b0);
    rd(0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("cl_pending", commit_pending, 1);
    tick();
    chk("cl_done", commit_done, 1);
    msel = ~msel;
    chk("cl_bank_sel", bank_sel, msel);
    rd(0);
    rd(1);
    rd(3);

    // Asynchronous reset mid-sweep with a commit pending.
    start_sweep();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    chk("mid_pending", commit_pending, 1);
    chk("mid_valid", s_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_s_valid", s_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_data", s_data, 0);
    chk("arst_s_last", s_last, 0);
    chk("arst_q0", q0, 0);
    chk("arst_pending", commit_pending, 0);
    chk("arst_bank_sel", bank_sel, 0);
    sb.delete();
    msel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_pending", commit_pending, 0);
    chk("post_done", commit_done, 0);
    rd(3);
    start_sweep();
    sweep_fixed(0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
